br_amba_axi_burst_sequencer: RTL and testbench
==============================================

Name: br_amba_axi_burst_sequencer

Overview:
- Accepts one AXI burst command (addr, len, size, burst type) per handshake and expands it into a stream of per-beat addresses, one beat per ready/valid transfer.
- Sits behind an AXI subordinate's AW or AR channel, ahead of an SRAM or register datapath.
- Sequences FIXED, INCR and WRAP bursts.
- Flags illegal bursts with a per-beat SLVERR response instead of dropping them, so the beat count always equals len+1.

Parameters:
- AddrWidth, 32: width of cmd_addr and beat_addr; must be >= 12.
- DataWidth, 64: datapath width in bits; power of 2, 8..1024. MaxSize = log2(DataWidth/8).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command valid.
- cmd_ready  output  1  command ready.
- cmd_addr  input  AddrWidth  burst start address.
- cmd_len  input  8  beats minus one (AxLEN).
- cmd_size  input  3  log2 bytes per beat (AxSIZE).
- cmd_burst  input  2  burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- beat_valid  output  1  beat valid.
- beat_ready  input  1  beat ready.
- beat_addr  output  AddrWidth  address of current beat.
- beat_idx  output  8  beat number, 0..len.
- beat_last  output  1  final beat of burst.
- beat_resp  output  2  0 OKAY, or 2 SLVERR for an illegal command.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: FSM goes to IDLE; beat_valid=0, beat_addr=0, beat_idx=0, beat_last=0, beat_resp=0; cmd_ready=1 once rst_n is deasserted.
- FSM states:
  - IDLE: cmd_ready=1, beat_valid=0.
  - ACTIVE: beat_valid=1.
- Transitions:
  - IDLE -> ACTIVE on cmd handshake.
  - ACTIVE -> IDLE on beat handshake with beat_last=1, unless a new command is accepted in the same cycle; then stay ACTIVE.
- cmd_ready = IDLE || (beat_valid && beat_ready && beat_last). This allows back-to-back bursts with no bubble.
- Latency: first beat is presented on the cycle after command acceptance (registered outputs).
- The command is captured into internal registers; cmd_* inputs are don't-care after the handshake.
- Stall: while beat_valid && !beat_ready, all beat_* outputs hold stable. beat_valid never drops without a handshake.
- Beat 0: beat_addr = cmd_addr unmodified (unaligned start allowed for FIXED and INCR).
- Aligned base: A = cmd_addr with the low cmd_size bits cleared.
- FIXED: every beat_addr = cmd_addr.
- INCR: beat n (n>=1) address = A + n*2^size, computed modulo 2^AddrWidth.
- WRAP:
  - Container = (len+1)*2^size bytes.
  - Lower bound = cmd_addr rounded down to a Container multiple.
  - Next address = current + 2^size; when it reaches lower bound + Container, it returns to lower bound.
- beat_idx counts 0..len; beat_last = (beat_idx == len).
- Illegal command, any of:
  - cmd_burst=3.
  - cmd_size > MaxSize.
  - FIXED with len > 15.
  - WRAP with len not in {1,3,7,15}.
  - WRAP with cmd_addr not aligned to 2^size.
  - INCR where the last byte address crosses a 4KB boundary relative to cmd_addr.
- Illegal-command handling: still emits len+1 beats, all with beat_resp=SLVERR and beat_addr held at cmd_addr. beat_idx and beat_last behave normally.
- Legal commands: beat_resp=OKAY on every beat.
- Address arithmetic is done in AddrWidth+1 bits; the carry is used only for the 4KB check.
- Reset mid-burst aborts immediately: the outputs take their reset values asynchronously, and no partial burst resumes after reset.
- cmd_len=0: a single beat with beat_last=1 in its first cycle.

Test Plan:
- INCR, addr=0x1004, len=3, size=2, beat_ready held high -> beat_addr 0x1004, 0x1008, 0x100C, 0x1010; beat_idx 0..3; beat_last on 4th beat; resp OKAY.
- WRAP, addr=0x38, len=3, size=3 -> beat_addr 0x38, 0x20, 0x28, 0x30; beat_last on 0x30.
- Two back-to-back INCR len=0 commands, beat_ready=1 -> second cmd_ready high in the same cycle as the first beat handshake; beats on consecutive cycles, no bubble.
- FIXED, addr=0x40, len=2, with beat_ready toggled 1,0,0,1,1 -> outputs stable during the stall; three beats, all 0x40.
- Illegal commands:
  - cmd_burst=3, len=1 -> two beats, both beat_resp=2, beat_addr=cmd_addr.
  - INCR addr=0xFF8, size=3, len=1 (crosses 4KB) -> two beats, both SLVERR.
- Assert rst_n low during beat 2 of an INCR len=7 burst -> beat_valid=0 immediately; after release, cmd_ready=1 and no stale beats are emitted.

Source files
------------

// File: rtl/br_amba_axi_burst_sequencer.sv
// Purpose: expands one AXI burst command (FIXED/INCR/WRAP) into per-beat addresses; illegal bursts yield len+1 SLVERR beats.
// Latency: first beat is presented the cycle after command acceptance; then one beat per beat handshake.
// Backpressure: beat_* hold while beat_ready is low; cmd_ready rises on the final beat handshake for bubble-free bursts.
// Ports: clk/rst_n; cmd_valid/cmd_ready with cmd_addr/cmd_len/cmd_size/cmd_burst; beat_valid/beat_ready with
//        beat_addr/beat_idx/beat_last/beat_resp.
module br_amba_axi_burst_sequencer #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [AddrWidth-1:0] cmd_addr,
    input  logic [7:0]           cmd_len,
    input  logic [2:0]           cmd_size,
    input  logic [1:0]           cmd_burst,
    output logic                 beat_valid,
    input  logic                 beat_ready,
    output logic [AddrWidth-1:0] beat_addr,
    output logic [7:0]           beat_idx,
    output logic                 beat_last,
    output logic [1:0]           beat_resp
);
    localparam int MaxSize = $clog2(DataWidth / 8);

    localparam logic [1:0] BurstFixed = 2'd0;
    localparam logic [1:0] BurstIncr  = 2'd1;
    localparam logic [1:0] BurstWrap  = 2'd2;
    localparam logic [1:0] BurstRsvd  = 2'd3;

    localparam logic [1:0] RespOkay   = 2'd0;
    localparam logic [1:0] RespSlverr = 2'd2;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t               state;
    logic [AddrWidth-1:0] step_q;   // 2^size
    logic [AddrWidth-1:0] amask_q;  // 2^size - 1 (size alignment)
    logic [AddrWidth-1:0] wmask_q;  // container - 1 (wrap window)
    logic [7:0]           len_q;
    logic [1:0]           burst_q;
    logic                 err_q;

    logic [AddrWidth-1:0] cmd_step;
    logic [AddrWidth-1:0] cmd_amask;
    logic [AddrWidth-1:0] cmd_wmask;
    logic [16:0]          page_end;
    logic                 cmd_illegal;
    logic                 wrap_len_ok;
    logic                 cmd_fire;
    logic                 beat_fire;
    logic [AddrWidth-1:0] next_addr;

    assign beat_fire = beat_valid && beat_ready;
    assign cmd_ready = (state == IDLE) || (beat_fire && beat_last);
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign cmd_step  = AddrWidth'(1) << cmd_size;
    assign cmd_amask = cmd_step - AddrWidth'(1);
    assign cmd_wmask = ((AddrWidth'(cmd_len) + AddrWidth'(1)) << cmd_size) - AddrWidth'(1);

    // One past the last byte, measured from the start of the 4KB page holding
    // the aligned base; a value above 4096 means the burst leaves the page.
    assign page_end = {5'd0, cmd_addr[11:0] & ~cmd_amask[11:0]}
                    + ((17'(cmd_len) + 17'd1) << cmd_size);

    assign wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                         (cmd_len == 8'd7) || (cmd_len == 8'd15);

    always_comb begin
        cmd_illegal = 1'b0;
        if (cmd_burst == BurstRsvd)                                    cmd_illegal = 1'b1;
        if (cmd_size > 3'(MaxSize))                                    cmd_illegal = 1'b1;
        if (cmd_burst == BurstFixed && cmd_len > 8'd15)                cmd_illegal = 1'b1;
        if (cmd_burst == BurstWrap && !wrap_len_ok)                    cmd_illegal = 1'b1;
        if (cmd_burst == BurstWrap && (cmd_addr & cmd_amask) != '0)    cmd_illegal = 1'b1;
        if (cmd_burst == BurstIncr && page_end > 17'h1000)             cmd_illegal = 1'b1;
    end

    // Beat 0 may be unaligned for INCR, so realign before stepping. WRAP keeps
    // the bits above the container fixed and lets the low bits roll over.
    always_comb begin
        next_addr = beat_addr;
        if (!err_q) begin
            case (burst_q)
                BurstIncr: next_addr = (beat_addr & ~amask_q) + step_q;
                BurstWrap: next_addr = (beat_addr & ~wmask_q) | ((beat_addr + step_q) & wmask_q);
                default:   next_addr = beat_addr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_valid <= 1'b0;
            beat_addr  <= '0;
            beat_idx   <= 8'd0;
            beat_last  <= 1'b0;
            beat_resp  <= RespOkay;
            step_q     <= '0;
            amask_q    <= '0;
            wmask_q    <= '0;
            len_q      <= 8'd0;
            burst_q    <= BurstFixed;
            err_q      <= 1'b0;
        end else if (cmd_fire) begin
            // Covers both IDLE acceptance and back-to-back acceptance on the last beat.
            state      <= ACTIVE;
            beat_valid <= 1'b1;
            beat_addr  <= cmd_addr;
            beat_idx   <= 8'd0;
            beat_last  <= (cmd_len == 8'd0);
            beat_resp  <= cmd_illegal ? RespSlverr : RespOkay;
            step_q     <= cmd_step;
            amask_q    <= cmd_amask;
            wmask_q    <= cmd_wmask;
            len_q      <= cmd_len;
            burst_q    <= cmd_burst;
            err_q      <= cmd_illegal;
        end else if (beat_fire) begin
            if (beat_last) begin
                state      <= IDLE;
                beat_valid <= 1'b0;
                beat_last  <= 1'b0;
            end else begin
                beat_addr <= next_addr;
                beat_idx  <= beat_idx + 8'd1;
                beat_last <= ((beat_idx + 8'd1) == len_q);
            end
        end
    end
endmodule

// File: tb/tb_br_amba_axi_burst_sequencer.sv
module tb_br_amba_axi_burst_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic        beat_valid;
    logic        beat_ready = 1'b1;
    logic [31:0] beat_addr;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic [1:0]  beat_resp;

    int checks = 0;
    int errors = 0;

    br_amba_axi_burst_sequencer #(.AddrWidth(32), .DataWidth(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_addr(beat_addr), .beat_idx(beat_idx), .beat_last(beat_last), .beat_resp(beat_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] exp_addr [4];
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input string n, input logic [31:0] a, input logic [7:0] l,
                        input logic [2:0] s, input logic [1:0] b, input logic [1:0] r,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [31:0] e3);
        vecs[i].name = n; vecs[i].addr = a; vecs[i].len = l; vecs[i].size = s;
        vecs[i].burst = b; vecs[i].exp_resp = r;
        vecs[i].exp_addr[0] = e0; vecs[i].exp_addr[1] = e1;
        vecs[i].exp_addr[2] = e2; vecs[i].exp_addr[3] = e3;
    endtask

    // Called at a negedge: presents a command for one rising edge and returns at the next negedge.
    task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_addr = 32'hDEAD_BEEF; cmd_len = 8'hAA; cmd_size = 3'd7; cmd_burst = 2'd3;
        @(negedge clk);
    endtask

    initial begin
        setv(0,  "incr_basic",   32'h1004, 8'd3, 3'd2, 2'd1, 2'd0, 32'h1004, 32'h1008, 32'h100C, 32'h1010);
        setv(1,  "wrap_basic",   32'h0038, 8'd3, 3'd3, 2'd2, 2'd0, 32'h0038, 32'h0020, 32'h0028, 32'h0030);
        setv(2,  "fixed",        32'h0040, 8'd2, 3'd2, 2'd0, 2'd0, 32'h0040, 32'h0040, 32'h0040, 32'h0);
        setv(3,  "rsvd_burst",   32'h0123, 8'd1, 3'd0, 2'd3, 2'd2, 32'h0123, 32'h0123, 32'h0, 32'h0);
        setv(4,  "incr_4k_x",    32'h0FF8, 8'd1, 3'd3, 2'd1, 2'd2, 32'h0FF8, 32'h0FF8, 32'h0, 32'h0);
        setv(5,  "incr_unalign", 32'h1003, 8'd2, 3'd2, 2'd1, 2'd0, 32'h1003, 32'h1004, 32'h1008, 32'h0);
        setv(6,  "wrap_unalign", 32'h003A, 8'd3, 3'd3, 2'd2, 2'd2, 32'h003A, 32'h003A, 32'h003A, 32'h003A);
        setv(7,  "size_too_big", 32'h0100, 8'd0, 3'd4, 2'd1, 2'd2, 32'h0100, 32'h0, 32'h0, 32'h0);
        setv(8,  "wrap_bad_len", 32'h0040, 8'd2, 3'd2, 2'd2, 2'd2, 32'h0040, 32'h0040, 32'h0040, 32'h0);
        setv(9,  "incr_len0",    32'h2000, 8'd0, 3'd0, 2'd1, 2'd0, 32'h2000, 32'h0, 32'h0, 32'h0);
        setv(10, "wrap_small",   32'h000C, 8'd1, 3'd2, 2'd2, 2'd0, 32'h000C, 32'h0008, 32'h0, 32'h0);
        setv(11, "incr_4k_edge", 32'h0FF0, 8'd1, 3'd3, 2'd1, 2'd0, 32'h0FF0, 32'h0FF8, 32'h0, 32'h0);

        // Reset state
        #2;
        check("rst_beat_valid", {31'd0, beat_valid}, 32'd0);
        check("rst_beat_addr", beat_addr, 32'd0);
        check("rst_beat_idx", {24'd0, beat_idx}, 32'd0);
        check("rst_beat_last", {31'd0, beat_last}, 32'd0);
        check("rst_beat_resp", {30'd0, beat_resp}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Table-driven bursts with beat_ready held high
        beat_ready = 1'b1;
        for (int v = 0; v < 12; v++) begin
            issue(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
            for (int b = 0; b <= int'(vecs[v].len); b++) begin
                check({vecs[v].name, "_valid"}, {31'd0, beat_valid}, 32'd1);
                check({vecs[v].name, "_addr"}, beat_addr, vecs[v].exp_addr[b]);
                check({vecs[v].name, "_idx"}, {24'd0, beat_idx}, b);
                check({vecs[v].name, "_last"}, {31'd0, beat_last}, (b == int'(vecs[v].len)) ? 32'd1 : 32'd0);
                check({vecs[v].name, "_resp"}, {30'd0, beat_resp}, {30'd0, vecs[v].exp_resp});
                @(negedge clk);
            end
            check({vecs[v].name, "_idle"}, {31'd0, beat_valid}, 32'd0);
        end

        // Back-to-back len=0 INCR bursts: no bubble between them
        cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_len = 8'd0; cmd_size = 3'd2; cmd_burst = 2'd1;
        @(posedge clk);
        #1;
        cmd_addr = 32'h200;
        @(negedge clk);
        check("b2b_first_addr", beat_addr, 32'h100);
        check("b2b_first_last", {31'd0, beat_last}, 32'd1);
        check("b2b_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_valid", {31'd0, beat_valid}, 32'd1);
        check("b2b_second_addr", beat_addr, 32'h200);
        check("b2b_second_idx", {24'd0, beat_idx}, 32'd0);
        @(negedge clk);
        check("b2b_idle", {31'd0, beat_valid}, 32'd0);

        // FIXED burst with beat_ready pattern 1,0,0,1,1: outputs hold during the stall
        issue(32'h40, 8'd2, 3'd2, 2'd0);
        begin
            logic [4:0] rdy_pat;
            logic [7:0] exp_idx [5];
            rdy_pat = 5'b11001;  // bit c is beat_ready in cycle c
            exp_idx[0] = 8'd0; exp_idx[1] = 8'd1; exp_idx[2] = 8'd1; exp_idx[3] = 8'd1; exp_idx[4] = 8'd2;
            for (int c = 0; c < 5; c++) begin
                beat_ready = rdy_pat[c];
                check("stall_valid", {31'd0, beat_valid}, 32'd1);
                check("stall_addr", beat_addr, 32'h40);
                check("stall_idx", {24'd0, beat_idx}, {24'd0, exp_idx[c]});
                check("stall_last", {31'd0, beat_last}, (c == 4) ? 32'd1 : 32'd0);
                @(negedge clk);
            end
            beat_ready = 1'b1;
            check("stall_idle", {31'd0, beat_valid}, 32'd0);
        end

        // Reset during beat 2 of INCR len=7
        issue(32'h1000, 8'd7, 3'd2, 2'd1);
        @(negedge clk);
        @(negedge clk);
        check("mid_idx_before_rst", {24'd0, beat_idx}, 32'd2);
        check("mid_addr_before_rst", beat_addr, 32'h1008);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, beat_valid}, 32'd0);
        check("mid_rst_addr", beat_addr, 32'd0);
        check("mid_rst_idx", {24'd0, beat_idx}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            check("post_rst_no_beat", {31'd0, beat_valid}, 32'd0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
